// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch slice: data bus, reset vector,
// fetch FIFO entry and the fetch control FSM encoding.
package instr_fetch_unit_pkg;

  typedef logic [31:0] DATA_BUS;

  localparam DATA_BUS RESET_VEC_DEFAULT = 32'hBFC00000;

  typedef struct packed {
    DATA_BUS pc;
    DATA_BUS instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic DATA_BUS align_word(input DATA_BUS addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two >= 2; pointers carry an extra wrap bit.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads, buffers in-order responses and
// serves decode; redirects flush and drop stale responses. Option: FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int      FIFO_DEPTH = 4,
  parameter int      MAX_OUTST  = 4,
  parameter DATA_BUS RESET_VEC  = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready,
  output logic [31:0] fetch_count
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(MAX_OUTST) + 1;

  fetch_state_e  state, state_next;
  DATA_BUS       fetch_pc, fetch_pc_next;
  logic [OW-1:0] drop_cnt, drop_cnt_next;
  logic [OW-1:0] outst;
  logic [OW-1:0] outst_after;
  logic          active;

  logic          issue;
  logic          rsp_eff;
  logic          ifq_push;
  logic          ifq_pop;
  logic [CW-1:0] ifq_count;
  fetch_entry_t  ifq_head;
  fetch_entry_t  ifq_push_data;
  DATA_BUS       pq_head;
  logic [PW-1:0] pq_count;

  // The pending-PC queue holds exactly one entry per outstanding request.
  assign outst = OW'(pq_count);

  assign req_valid = active
                  && ((int'(outst) + int'(ifq_count)) < FIFO_DEPTH)
                  && (int'(outst) < MAX_OUTST);
  assign req_addr  = fetch_pc;
  assign issue     = req_valid && req_ready;
  assign rsp_eff   = rsp_valid && (outst != '0);
  assign outst_after = outst + OW'(issue) - OW'(rsp_eff);

  assign inst_valid = (ifq_count != '0);
  assign inst_pc    = inst_valid ? ifq_head.pc    : '0;
  assign inst_data  = inst_valid ? ifq_head.instr : '0;

  assign ifq_push_data = '{pc: pq_head, instr: rsp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_VEC;
      drop_cnt <= '0;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      drop_cnt <= drop_cnt_next;
      active   <= 1'b1;
    end
  end

  // Redirect wins; stale words are counted off in DRAIN instead of being buffered.
  always_comb begin
    fetch_pc_next = fetch_pc;
    drop_cnt_next = drop_cnt;
    ifq_push      = 1'b0;
    ifq_pop       = 1'b0;
    if (redirect_valid) begin
      fetch_pc_next = align_word(redirect_pc);
      drop_cnt_next = outst_after;
    end else begin
      if (issue) fetch_pc_next = fetch_pc + 32'd4;
      ifq_pop = inst_valid && inst_ready;
      if (rsp_eff) begin
        case (state)
          FETCH:   ifq_push      = 1'b1;
          DRAIN:   drop_cnt_next = drop_cnt - OW'(1);
          default: ifq_push      = 1'b0;
        endcase
      end
    end
    state_next = (drop_cnt_next != '0) ? DRAIN : FETCH;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ifq_push),
    .push_data (ifq_push_data),
    .pop       (ifq_pop),
    .flush     (redirect_valid),
    .head_data (ifq_head),
    .count     (ifq_count)
  );

  fetch_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(DATA_BUS))
  ) u_pending_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (rsp_eff),
    .flush     (1'b0),
    .head_data (pq_head),
    .count     (pq_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt <= '0;
    else if (ifq_pop) perf_cnt <= perf_cnt + 32'd1;
  end

  assign fetch_count = perf_cnt;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: ROM model with variable
// latency, random redirects/backpressure, epoch-based reference of the fetch stream.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int FD = 4;
  localparam int MO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic [31:0] fetch_count;

  instr_fetch_unit #(
    .FIFO_DEPTH (FD),
    .MAX_OUTST  (MO),
    .RESET_VEC  (32'hBFC00000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          tag;
    int          due;
  } rom_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  rom_req_t    rom_q[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          issued = 0;
  int          hs_total = 0;
  logic [31:0] issue_pc = 32'hBFC00000;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: ROM response, redirect, random ready signals.
  task automatic doCycle(input int rr, input int ir, input bit redir, input logic [31:0] tgt);
    rom_req_t e;
    bit       have_rsp;
    int       due;
    @(negedge clk);
    cyc++;
    have_rsp = 1'b0;
    if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
      e = rom_q.pop_front();
      have_rsp = 1'b1;
      rsp_valid = 1'b1;
      rsp_data  = rom_word(e.addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    redirect_valid = redir;
    redirect_pc    = tgt;
    req_ready  = ($urandom_range(0, 99) < rr);
    inst_ready = ($urandom_range(0, 99) < ir);
    if (req_valid && req_ready) begin
      issued++;
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rom_q.push_back('{addr: issue_pc, tag: epoch, due: due});
      issue_pc = issue_pc + 32'd4;
    end
    if (have_rsp && e.tag == epoch && !redir)
      sb.push_back('{pc: e.addr, data: rom_word(e.addr)});
    if (redir) begin
      sb.delete();
      epoch++;
      issue_pc = {tgt[31:2], 2'b00};
    end
  endtask

  task automatic applyStimulus(input int n, input int rr, input int ir, input int redir_pct);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF4 + 32'($urandom_range(0, 11))) : $urandom;
      doCycle(rr, ir, ($urandom_range(0, 99) < redir_pct), tgt);
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    rom_q.delete();
    sb.delete();
    epoch++;
    issue_pc = 32'hBFC00000;
    last_due = cyc;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: request address stream and decode-side handshakes against the models.
  logic [31:0] req_next = 32'hBFC00000;
  int          hs_count = 0;
  int          mcyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      mcyc++;
      if (!rst_n) begin
        req_next = 32'hBFC00000;
        hs_count = 0;
        checkOutput("rst_req_valid", 32'(req_valid), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_word", inst_pc | inst_data, 32'd0);
        checkOutput("rst_fetch_count", fetch_count, 32'd0);
      end else begin
        if (mcyc % 8 == 0) begin
`ifdef FETCH_PERF_CNT_EN
          checkOutput("fetch_count", fetch_count, 32'(hs_count));
`else
          checkOutput("fetch_count", fetch_count, 32'd0);
`endif
        end
        if (req_valid && req_ready) begin
          checkOutput("req_addr", req_addr, req_next);
          req_next = req_next + 32'd4;
        end
        if (redirect_valid) req_next = {redirect_pc[31:2], 2'b00};
        if (inst_valid && inst_ready && !redirect_valid) begin
          hs_count++;
          hs_total++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_inst actual_pc=%h required=none", inst_pc);
          end else begin
            e = sb.pop_front();
            checkOutput("inst_pc", inst_pc, e.pc);
            checkOutput("inst_data", inst_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Decode stalled: credits must stop issue at FIFO_DEPTH requests.
    issued = 0;
    for (int i = 0; i < 20; i++) doCycle(100, 0, 1'b0, 32'd0);
    checkOutput("bp_issued", 32'(issued), 32'(FD));
    checkOutput("bp_req_valid", 32'(req_valid), 32'd0);
    applyStimulus(10, 0, 100, 0);

    applyStimulus(5, 100, 100, 0);
    doCycle(100, 100, 1'b1, 32'hBFC00102);
    applyStimulus(8, 100, 100, 0);

    lat_lo = 3;
    lat_hi = 3;
    applyStimulus(6, 100, 100, 0);
    doCycle(100, 100, 1'b1, 32'hBFC00100);
    applyStimulus(12, 100, 100, 0);

    lat_lo = 1;
    lat_hi = 1;
    doCycle(100, 100, 1'b1, 32'hFFFFFFF8);
    applyStimulus(8, 100, 100, 0);

    lat_lo = 1;
    lat_hi = 3;
    applyStimulus(1500, 70, 60, 8);
    doReset(2);
    applyStimulus(500, 80, 50, 5);

    applyStimulus(30, 0, 100, 0);
    @(negedge clk);
    #3;
    checkOutput("sb_left", 32'(sb.size()), 32'd0);
    checkOutput("inst_valid_end", 32'(inst_valid), 32'd0);
    checkOutput("handshakes_seen", 32'(hs_total >= 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
